// File: rtl/minisys_gpio_ctrl.sv
// minisys_gpio_ctrl
//   Memory-mapped switch/LED controller for the minisys single-cycle CPU.
//   Switch pins pass through a 2-flop synchroniser and a shared-tick
//   debouncer; every accepted level change sets a sticky per-bit flag that
//   can raise a maskable level interrupt. LEDs are driven from a data
//   register with optional per-bit blinking at a programmable rate.
//
// Ports
//   clk       system clock
//   rst       synchronous reset, active-low
//   io_rd     register read strobe (one cycle)
//   io_wr     register write strobe (one cycle)
//   io_addr   word register index
//   io_wdata  write data
//   io_rdata  read data, registered (1-cycle latency, held when io_rd=0)
//   switch    raw asynchronous switch pins
//   led       LED pins (registered)
//   irq       level interrupt = |(SW_EDGE & EDGE_MASK)
//
// Register map (io_addr)
//   0 SW_DATA   RO   debounced switches
//   1 SW_EDGE   W1C  sticky change flags
//   2 LED_DATA  RW
//   3 LED_BLINK RW   per-bit blink enable
//   4 BLINK_DIV RW   cycles per blink half-period (0 behaves as 1)
//   5 EDGE_MASK RW
//   6,7         read 0, writes ignored
//
// Bus protocol: io_rd and io_wr are single-cycle strobes with no
// back-pressure (the block is always ready). A write takes effect on the
// edge where io_wr=1; a read loads io_rdata on the edge where io_rd=1 with
// the pre-write contents, so a simultaneous read/write of one register
// returns the old value.
module minisys_gpio_ctrl #(
  parameter int          SW_W          = 24,
  parameter int          LED_W         = 24,
  parameter int          DEB_CYCLES    = 20000,
  parameter logic [31:0] BLINK_DIV_RST = 32'd25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [2:0]       io_addr,
  input  logic [31:0]      io_wdata,
  output logic [31:0]      io_rdata,
  input  logic [SW_W-1:0]  switch,
  output logic [LED_W-1:0] led,
  output logic             irq
);

  localparam int DEB_CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [SW_W-1:0]   sync0;
  logic [SW_W-1:0]   sync1;
  logic [DEB_CW-1:0] deb_cnt;
  logic [SW_W-1:0]   deb_sample;
  logic [SW_W-1:0]   sw_data;
  logic [SW_W-1:0]   sw_edge;
  logic [SW_W-1:0]   edge_mask;
  logic [LED_W-1:0]  led_data;
  logic [LED_W-1:0]  led_blink;
  logic [31:0]       blink_div;
  logic [31:0]       blink_cnt;
  logic              blink_phase;

  logic              tick;
  logic [SW_W-1:0]   match;
  logic [SW_W-1:0]   sw_data_next;
  logic [SW_W-1:0]   edge_clr;
  logic [SW_W-1:0]   sw_edge_next;
  logic [31:0]       blink_div_eff;
  logic              blink_wrap;
  logic [31:0]       rd_mux;

  logic wr_sw_edge, wr_led_data, wr_led_blink, wr_blink_div, wr_edge_mask;

  assign wr_sw_edge   = io_wr && (io_addr == 3'd1);
  assign wr_led_data  = io_wr && (io_addr == 3'd2);
  assign wr_led_blink = io_wr && (io_addr == 3'd3);
  assign wr_blink_div = io_wr && (io_addr == 3'd4);
  assign wr_edge_mask = io_wr && (io_addr == 3'd5);

  assign tick = (deb_cnt == DEB_CW'(DEB_CYCLES - 1));

  // A bit is accepted only when the synchronised level equals the level
  // seen at the previous tick, i.e. it has been stable across two ticks.
  assign match = ~(sync1 ^ deb_sample);

  always_comb begin
    sw_data_next = sw_data;
    if (tick) begin
      sw_data_next = (sw_data & ~match) | (sync1 & match);
    end
  end

  // Set (a change of SW_DATA on this edge) overrides a simultaneous W1C.
  assign edge_clr     = wr_sw_edge ? io_wdata[SW_W-1:0] : '0;
  assign sw_edge_next = (sw_edge & ~edge_clr) | (sw_data ^ sw_data_next);

  assign blink_div_eff = (blink_div == 32'd0) ? 32'd1 : blink_div;
  assign blink_wrap    = (blink_cnt == blink_div_eff - 32'd1);

  always_comb begin
    rd_mux = '0;
    case (io_addr)
      3'd0:    rd_mux = 32'(sw_data);
      3'd1:    rd_mux = 32'(sw_edge);
      3'd2:    rd_mux = 32'(led_data);
      3'd3:    rd_mux = 32'(led_blink);
      3'd4:    rd_mux = blink_div;
      3'd5:    rd_mux = 32'(edge_mask);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync0       <= '0;
      sync1       <= '0;
      deb_cnt     <= '0;
      deb_sample  <= '0;
      sw_data     <= '0;
      sw_edge     <= '0;
      edge_mask   <= '0;
      led_data    <= '0;
      led_blink   <= '0;
      blink_div   <= BLINK_DIV_RST;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      led         <= '0;
      io_rdata    <= '0;
    end else begin
      sync0   <= switch;
      sync1   <= sync0;
      deb_cnt <= tick ? '0 : deb_cnt + DEB_CW'(1);
      if (tick) begin
        deb_sample <= sync1;
      end
      sw_data <= sw_data_next;
      sw_edge <= sw_edge_next;

      if (wr_led_data)  led_data  <= io_wdata[LED_W-1:0];
      if (wr_led_blink) led_blink <= io_wdata[LED_W-1:0];
      if (wr_edge_mask) edge_mask <= io_wdata[SW_W-1:0];

      // Reprogramming the divider restarts the half-period but keeps phase.
      if (wr_blink_div) begin
        blink_div <= io_wdata;
        blink_cnt <= '0;
      end else if (blink_wrap) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 32'd1;
      end

      led <= led_data & (~led_blink | {LED_W{blink_phase}});

      if (io_rd) begin
        io_rdata <= rd_mux;
      end
    end
  end

  assign irq = |(sw_edge & edge_mask);

endmodule

// File: doc/minisys_gpio_ctrl.md
Name: minisys_gpio_ctrl

Overview:
- Parametrised memory-mapped switch/LED controller for the minisys single-cycle CPU. It is the next generation of the fixed 24-bit switch-in/LED-out path.
- Adds a 2-flop synchroniser, shared-tick debounce, sticky change flags with a maskable interrupt, and per-bit LED blink with a programmable prescaler.
- Sits between the CPU's I/O read/write decode and the board switch/LED pins.

Parameters:
- SW_W, 24, switch input width (1..32)
- LED_W, 24, LED output width (1..32)
- DEB_CYCLES, 20000, clock cycles between debounce sample ticks (>=2)
- BLINK_DIV_RST, 32'd25000000, reset value of BLINK_DIV register (cycles per blink half-period)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- io_rd  in  1  register read strobe (one cycle)
- io_wr  in  1  register write strobe (one cycle)
- io_addr  in  3  word register index
- io_wdata  in  32  write data
- io_rdata  out  32  read data, registered
- switch  in  SW_W  raw asynchronous switch pins
- led  out  LED_W  LED pins
- irq  out  1  level interrupt = |(SW_EDGE & EDGE_MASK)

Behaviour:
- Reset: on a clk edge with rst=0, the following are cleared:
  - io_rdata=0, led=0, irq=0
  - sync flops, SW_DATA, SW_EDGE, LED_DATA, LED_BLINK, EDGE_MASK = 0
  - debounce tick counter=0, blink counter=0, blink phase=0
  - BLINK_DIV=BLINK_DIV_RST
- Reset mid-operation aborts everything in the same edge; no pending flags survive.
- Register map (io_addr). Widths are zero-extended on read; write bits above the width are ignored.
  - 0 SW_DATA: RO, debounced switches. Writes ignored.
  - 1 SW_EDGE: W1C sticky per-bit change flags.
  - 2 LED_DATA: RW.
  - 3 LED_BLINK: RW, per-bit blink enable.
  - 4 BLINK_DIV: RW, 32 bits. Value 0 is treated as 1.
  - 5 EDGE_MASK: RW, SW_W bits.
  - 6,7: read 0, writes ignored.
- Read: io_rdata loads the selected register on the edge where io_rd=1, i.e. 1-cycle latency. io_rdata holds its value when io_rd=0.
- io_rd and io_wr in the same cycle: the write takes effect, and the read returns the pre-write value.
- Synchroniser: sw_s = switch delayed 2 flops.
- Debounce:
  - Tick counter counts 0..DEB_CYCLES-1 and pulses tick at the wrap.
  - On tick, per bit: if sw_s[i] equals the sample taken at the previous tick, SW_DATA[i] takes sw_s[i]; the sample register is always updated on tick.
  - Net effect: a level change is accepted after 2 consecutive matching ticks. Latency is between DEB_CYCLES+3 and 2*DEB_CYCLES+3 cycles after the pin change.
  - Glitches shorter than DEB_CYCLES are never accepted.
- Edge flags:
  - When SW_DATA[i] changes, SW_EDGE[i] is set on the same edge.
  - W1C clears the bits written as 1.
  - Set and clear in the same cycle: set wins.
- irq is combinational from the registered SW_EDGE/EDGE_MASK, so it is valid the cycle after the flag sets.
- Blink:
  - Blink counter counts 0..BLINK_DIV-1. At the wrap, phase toggles and the counter restarts.
  - A write to BLINK_DIV resets the counter to 0 (phase unchanged).
  - Per bit: led[i] = LED_DATA[i] & (~LED_BLINK[i] | phase), registered. led therefore lags a LED_DATA write by 1 cycle.
- Arithmetic: counters are unsigned and wrap only at their terminal values; no overflow is possible.

Test Plan:
- Reset/readback (DEB_CYCLES=4, BLINK_DIV_RST=8): hold rst=0 for 3 cycles, then release.
  - Read addr 0..7 → 0,0,0,0,8,0,0,0.
  - led=0, irq=0.
- Debounce (switch=24'h00F876 before reset): after reset, set switch[23:21]=3'b001.
  - SW_DATA reads 24'h20F876 within 2*4+3 cycles.
  - SW_EDGE=24'h200000 plus the initial 0→F876 bits = 24'h20F876.
  - A 2-cycle pulse on switch[0] is never accepted.
- Interrupt/W1C: EDGE_MASK=24'h200000 → irq=1.
  - Write SW_EDGE=24'h200000 → irq=0 next cycle; other flags remain.
  - Toggle bit21 so the flag re-sets in the same cycle as a W1C → flag stays 1.
- LED static: write LED_DATA=32'hFFABCDEF (LED_W=24).
  - led=24'hABCDEF one cycle later.
  - Readback=32'h00ABCDEF.
- Blink: LED_BLINK=24'h00000F, BLINK_DIV=8.
  - led[3:0] alternates 4'hF/4'h0 every 8 cycles, with the first toggle 8 cycles after the BLINK_DIV write.
  - Other bits stay static.
  - BLINK_DIV=0 behaves as 1, toggling every cycle.
- Read/write collision: io_rd=io_wr=1 on addr 2 with wdata=5 while LED_DATA=3.
  - io_rdata=3.
  - A subsequent read returns 5.
